// File: rtl/branch_detect_unit_pkg.sv
// Shared definitions for the MEM-stage branch resolver.
//   - br_type_e     : encodings of the 2-bit branch class carried down the pipe
//   - DEFAULT_CNT_W : default width of the branch statistics counters
package branch_detect_unit_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_BLTZ = 2'b11
    } br_type_e;

    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/branch_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
// Once the count reaches all-ones it holds there instead of wrapping.
//
// Ports:
//   i_clk    : clock, state updates on the rising edge
//   i_rst    : synchronous active-high reset, wins over i_en
//   i_en     : count one step on this edge (ignored when saturated)
//   o_count  : current count value
module branch_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_detect_unit.sv
// MEM-stage branch resolver. Decodes the branch class against the ALU
// Zero/Sign flags into a combinational taken signal (drives PC-source select
// and the IF/ID/EX flush), registers a one-cycle-late flush pulse, and keeps
// saturating counts of resolved and taken branches.
//
// Ports:
//   CLK            : system clock, rising-edge state updates
//   Reset          : synchronous active-high reset, overrides Stall
//   MEM_BranchType : 00 none, 01 beq, 10 bne, 11 bltz
//   MEM_Zero       : ALU result == 0
//   MEM_Sign       : ALU result sign bit
//   Stall          : freezes all registered state
//   Branch         : combinational branch-taken decision
//   Flush_q        : Branch delayed by one (non-stalled) edge
//   BranchCount    : number of resolved branch instructions (saturating)
//   TakenCount     : number of taken branches (saturating)
module branch_detect_unit
    import branch_detect_unit_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [1:0]       MEM_BranchType,
    input  logic             MEM_Zero,
    input  logic             MEM_Sign,
    input  logic             Stall,
    output logic             Branch,
    output logic             Flush_q,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount
);

    br_type_e w_br_type;
    logic     w_taken;
    logic     w_is_branch;
    logic     w_cnt_branch_en;
    logic     w_cnt_taken_en;
    logic     r_flush;

    assign w_br_type = br_type_e'(MEM_BranchType);

    // Flags not relevant to the active class are deliberately ignored.
    always_comb begin
        w_taken = 1'b0;
        case (w_br_type)
            BR_NONE: w_taken = 1'b0;
            BR_BEQ:  w_taken = MEM_Zero;
            BR_BNE:  w_taken = ~MEM_Zero;
            BR_BLTZ: w_taken = MEM_Sign;
            default: w_taken = 1'b0;
        endcase
    end

    assign Branch      = w_taken;
    assign w_is_branch = (w_br_type != BR_NONE);

    // Taken implies a real branch class and both counters saturate at the
    // same value, so TakenCount can never overtake BranchCount.
    assign w_cnt_branch_en = ~Stall & w_is_branch;
    assign w_cnt_taken_en  = ~Stall & w_taken;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_flush <= 1'b0;
        end else if (!Stall) begin
            r_flush <= w_taken;
        end
    end

    assign Flush_q = r_flush;

    branch_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_branch (
        .i_clk   (CLK),
        .i_rst   (Reset),
        .i_en    (w_cnt_branch_en),
        .o_count (BranchCount)
    );

    branch_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_taken (
        .i_clk   (CLK),
        .i_rst   (Reset),
        .i_en    (w_cnt_taken_en),
        .o_count (TakenCount)
    );

endmodule

// File: tb/tb_branch_detect_unit.sv
module tb_branch_detect_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK;
    logic             Reset;
    logic [1:0]       MEM_BranchType;
    logic             MEM_Zero;
    logic             MEM_Sign;
    logic             Stall;
    logic             Branch;
    logic             Flush_q;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] TakenCount;

    int  n_checks;
    int  n_errors;
    bit  clk_run;

    int  m_flush;
    int  m_bc;
    int  m_tc;

    branch_detect_unit #(
        .CNT_W (CNT_W)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .MEM_BranchType (MEM_BranchType),
        .MEM_Zero       (MEM_Zero),
        .MEM_Sign       (MEM_Sign),
        .Stall          (Stall),
        .Branch         (Branch),
        .Flush_q        (Flush_q),
        .BranchCount    (BranchCount),
        .TakenCount     (TakenCount)
    );

    initial begin
        CLK = 1'b0;
        forever begin
            #5;
            if (clk_run) CLK = ~CLK;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decision straight from the branch-class table.
    function automatic int ref_taken(input int t, input int z, input int s);
        if (t == 1) return z;
        if (t == 2) return 1 - z;
        if (t == 3) return s;
        return 0;
    endfunction

    task automatic comb_case(input string tag, input logic [1:0] t, input logic z, input logic s);
        MEM_BranchType = t;
        MEM_Zero       = z;
        MEM_Sign       = s;
        #10;
        check(tag, 32'(Branch), 32'(ref_taken(int'(t), int'(z), int'(s))));
    endtask

    // One clocked cycle: drive on the falling edge, check Branch, then check
    // the registered outputs just after the rising edge against the model.
    task automatic step(input logic [1:0] t, input logic z, input logic s,
                        input logic st, input logic rs);
        int tk;
        @(negedge CLK);
        MEM_BranchType = t;
        MEM_Zero       = z;
        MEM_Sign       = s;
        Stall          = st;
        Reset          = rs;
        #1;
        tk = ref_taken(int'(t), int'(z), int'(s));
        check("branch_clk", 32'(Branch), 32'(tk));
        @(posedge CLK);
        if (rs) begin
            m_flush = 0;
            m_bc    = 0;
            m_tc    = 0;
        end else if (!st) begin
            m_flush = tk;
            if (t != 2'b00) m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
            if (tk == 1)    m_tc = (m_tc + 1 > CMAX) ? CMAX : m_tc + 1;
        end
        #1;
        check("flush_q", 32'(Flush_q), 32'(m_flush));
        check("branch_cnt", 32'(BranchCount), 32'(m_bc));
        check("taken_cnt", 32'(TakenCount), 32'(m_tc));
        check("taken_le_branch", 32'(TakenCount <= BranchCount), 32'd1);
    endtask

    int saved_bc;
    int saved_tc;
    int saved_fl;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        clk_run        = 1'b0;
        Reset          = 1'b0;
        Stall          = 1'b0;
        MEM_BranchType = 2'b00;
        MEM_Zero       = 1'b0;
        MEM_Sign       = 1'b0;
        m_flush        = 0;
        m_bc           = 0;
        m_tc           = 0;

        // Combinational truth table with the clock stopped.
        comb_case("tt_none",    2'b00, 1'b0, 1'b0);
        comb_case("tt_beq_z1",  2'b01, 1'b1, 1'b0);
        comb_case("tt_beq_z0",  2'b01, 1'b0, 1'b0);
        comb_case("tt_bne_z1",  2'b10, 1'b1, 1'b0);
        comb_case("tt_bne_z0",  2'b10, 1'b0, 1'b0);
        comb_case("tt_bltz_s1", 2'b11, 1'b0, 1'b1);
        comb_case("tt_bltz_s0", 2'b11, 1'b0, 1'b0);
        comb_case("tt_none2",   2'b00, 1'b1, 1'b1);
        // Flag independence.
        comb_case("ind_bltz_z0", 2'b11, 1'b0, 1'b0);
        comb_case("ind_bltz_z1", 2'b11, 1'b1, 1'b0);
        check("ind_bltz_const", 32'(Branch), 32'd0);
        comb_case("ind_beq_s0", 2'b01, 1'b1, 1'b0);
        comb_case("ind_beq_s1", 2'b01, 1'b1, 1'b1);
        check("ind_beq_const", 32'(Branch), 32'd1);

        clk_run = 1'b1;

        // Reset for two edges.
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_flush", 32'(Flush_q), 32'd0);
        check("rst_bc", 32'(BranchCount), 32'd0);
        check("rst_tc", 32'(TakenCount), 32'd0);

        // Counting sequence.
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq_fl0", 32'(Flush_q), 32'd1);
        step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq_fl1", 32'(Flush_q), 32'd0);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("seq_fl2", 32'(Flush_q), 32'd0);
        step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("seq_fl3", 32'(Flush_q), 32'd1);
        check("seq_bc", 32'(BranchCount), 32'd3);
        check("seq_tc", 32'(TakenCount), 32'd2);

        // Stall holds state while Branch still follows inputs.
        saved_bc = int'(BranchCount);
        saved_tc = int'(TakenCount);
        saved_fl = int'(Flush_q);
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stall_branch", 32'(Branch), 32'd1);
        check("stall_bc", 32'(BranchCount), 32'(saved_bc));
        check("stall_tc", 32'(TakenCount), 32'(saved_tc));
        check("stall_fl", 32'(Flush_q), 32'(saved_fl));

        // Reset overrides Stall.
        step(2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_stall_flush", 32'(Flush_q), 32'd0);
        check("rst_stall_bc", 32'(BranchCount), 32'd0);
        check("rst_stall_tc", 32'(TakenCount), 32'd0);

        // Saturation.
        for (int i = 0; i < 20; i++) step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_bc", 32'(BranchCount), 32'(CMAX));
        check("sat_tc", 32'(TakenCount), 32'(CMAX));

        // Randomized traffic with occasional stall and reset.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
